// File: rtl/aes_word_cnt_csr.sv
// Per-channel AES word counters with an Avalon-MM CSR window, sticky overflow
// flags and a maskable overflow interrupt.
module aes_word_cnt_csr #(
  parameter int unsigned BASE_ADDR    = 'h1000,
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned CNT_WIDTH    = 8,
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned REG_SIZE     = 32,
  parameter bit          SATURATE     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       word_inc,
  input  logic [ADDRESS_SIZE-1:0] avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [REG_SIZE-1:0]     avs_writedata,
  output logic [REG_SIZE-1:0]     avs_readdata,
  output logic                    avs_readdatavalid,
  output logic                    avs_waitrequest,
  output logic                    ovf_irq
);

  localparam logic [ADDRESS_SIZE-1:0] Base    = ADDRESS_SIZE'(BASE_ADDR);
  localparam logic [ADDRESS_SIZE-1:0] WinLast = ADDRESS_SIZE'(255);
  localparam logic [CNT_WIDTH-1:0]    CntMax  = '1;
  localparam logic [7:0]              OffCtrl = 8'h40;
  localparam logic [7:0]              OffStat = 8'h44;
  localparam logic [7:0]              OffMask = 8'h48;

  logic [ADDRESS_SIZE-1:0] rel;
  logic [7:0]              off;
  logic                    hit, wr_en, rd_en, clear;

  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0]    ovf_q, ovf_d, ovf_set, w1c;
  logic [NUM_CH-1:0]    mask_q, mask_d;
  logic                 freeze_q, freeze_d;
  logic [REG_SIZE-1:0]  rdata_q, rdata_d;
  logic                 rvalid_q, irq_q;
  logic                 unused_wdata;

  assign rel   = avs_address - Base;
  assign off   = rel[7:0];
  // Window covers exactly 256 bytes above the base; sub-word addresses never hit.
  assign hit   = (avs_address >= Base) && (rel <= WinLast) && (rel[1:0] == 2'b00);
  assign wr_en = avs_write && hit;
  assign rd_en = avs_read && !avs_write;
  assign clear = wr_en && (off == OffCtrl) && avs_writedata[0];
  assign unused_wdata = ^avs_writedata;

  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear) begin
        cnt_d[i] = '0;
      end else if (wr_en && (off == 8'(4 * i))) begin
        cnt_d[i] = avs_writedata[CNT_WIDTH-1:0];
      end else if (word_inc[i] && !freeze_q) begin
        if (cnt_q[i] == CntMax) begin
          ovf_set[i] = 1'b1;
          cnt_d[i]   = SATURATE ? CntMax : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w1c      = (wr_en && (off == OffStat)) ? avs_writedata[NUM_CH-1:0] : '0;
    // A new overflow in the same cycle wins over software clearing that bit.
    ovf_d    = clear ? '0 : ((ovf_q & ~w1c) | ovf_set);
    mask_d   = (wr_en && (off == OffMask)) ? avs_writedata[NUM_CH-1:0] : mask_q;
    freeze_d = (wr_en && (off == OffCtrl)) ? avs_writedata[1] : freeze_q;
  end

  always_comb begin
    rdata_d = '0;
    if (rd_en && hit) begin
      if (off == OffCtrl) begin
        rdata_d = REG_SIZE'({freeze_q, 1'b0});
      end else if (off == OffStat) begin
        rdata_d = REG_SIZE'(ovf_q);
      end else if (off == OffMask) begin
        rdata_d = REG_SIZE'(mask_q);
      end else begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
          if (off == 8'(4 * i)) rdata_d = REG_SIZE'(cnt_q[i]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= '0;
      ovf_q    <= '0;
      mask_q   <= '0;
      freeze_q <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= cnt_d[i];
      ovf_q    <= ovf_d;
      mask_q   <= mask_d;
      freeze_q <= freeze_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rd_en;
      irq_q    <= |(ovf_q & mask_q);
    end
  end

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign avs_waitrequest   = 1'b0;
  assign ovf_irq           = irq_q;

endmodule

// File: tb/tb_aes_word_cnt_csr.sv
// Bench for aes_word_cnt_csr: a wrapping and a saturating instance share stimulus
// and are checked against a register-level reference model.
module tb_aes_word_cnt_csr;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  word_inc;
  logic [31:0] avs_address, avs_writedata;
  logic        avs_read, avs_write;
  logic [31:0] rdata [2];
  logic [1:0]  rvalid, wreq, irq;

  always #5 clk = ~clk;

  aes_word_cnt_csr #(.SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .word_inc(word_inc), .avs_address(avs_address),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(rdata[0]), .avs_readdatavalid(rvalid[0]),
    .avs_waitrequest(wreq[0]), .ovf_irq(irq[0])
  );

  aes_word_cnt_csr #(.SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .word_inc(word_inc), .avs_address(avs_address),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(rdata[1]), .avs_readdatavalid(rvalid[1]),
    .avs_waitrequest(wreq[1]), .ovf_irq(irq[1])
  );

  // Reference model, index 0 = wrapping instance, 1 = saturating instance.
  logic [31:0] m_cnt [2][3];
  logic [31:0] m_stat [2];
  logic [31:0] m_mask [2];
  bit          m_freeze [2];
  bit          m_irq [2];
  logic [31:0] exp_rd [2];
  bit          exp_v;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic bit in_win(input logic [31:0] a);
    return (a >= 32'h1000) && (a <= 32'h10FF) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] model_read(input int s, input logic [31:0] a);
    logic [31:0] off;
    if (!in_win(a)) return 32'h0;
    off = a - 32'h1000;
    if (off < 32'd12) return m_cnt[s][off / 4];
    if (off == 32'h40) return m_freeze[s] ? 32'h2 : 32'h0;
    if (off == 32'h44) return m_stat[s];
    if (off == 32'h48) return m_mask[s];
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 3; c++) m_cnt[s][c] = 32'h0;
      m_stat[s] = 32'h0; m_mask[s] = 32'h0; m_freeze[s] = 1'b0; m_irq[s] = 1'b0;
    end
  endtask

  task automatic model_step(input int s, input logic [2:0] inc, input logic [31:0] a,
                            input bit wr, input logic [31:0] wd);
    logic [31:0] off;
    logic [31:0] newovf;
    bit w;
    off = a - 32'h1000;
    w = wr && in_win(a);
    newovf = 32'h0;
    m_irq[s] = (m_stat[s] & m_mask[s]) != 32'h0;
    if (w && off == 32'h40 && wd[0]) begin
      for (int c = 0; c < 3; c++) m_cnt[s][c] = 32'h0;
      m_stat[s] = 32'h0;
      m_freeze[s] = wd[1];
      return;
    end
    for (int c = 0; c < 3; c++) begin
      if (w && off == 32'(4 * c)) begin
        m_cnt[s][c] = wd & 32'hFF;
      end else if (inc[c] && !m_freeze[s]) begin
        if (m_cnt[s][c] == 32'd255) begin
          newovf = newovf | (32'h1 << c);
          m_cnt[s][c] = (s == 1) ? 32'd255 : 32'd0;
        end else begin
          m_cnt[s][c] = m_cnt[s][c] + 32'd1;
        end
      end
    end
    if (w && off == 32'h44) m_stat[s] = m_stat[s] & ~wd;
    m_stat[s] = (m_stat[s] | newovf) & 32'h7;
    if (w && off == 32'h48) m_mask[s] = wd & 32'h7;
    if (w && off == 32'h40) m_freeze[s] = wd[1];
  endtask

  // One bus cycle: drive at negedge, model advances at posedge, outputs ready at next negedge.
  task automatic step(input logic [2:0] inc, input logic [31:0] a, input bit rd, input bit wr,
                      input logic [31:0] wd);
    word_inc = inc; avs_address = a; avs_read = rd; avs_write = wr; avs_writedata = wd;
    exp_v = rd && !wr;
    for (int s = 0; s < 2; s++) exp_rd[s] = exp_v ? model_read(s, a) : 32'h0;
    @(posedge clk);
    for (int s = 0; s < 2; s++) model_step(s, inc, a, wr, wd);
    @(negedge clk);
    word_inc = 3'b000; avs_address = 32'h0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    word_inc = 3'b000; avs_address = 32'h0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_total++;
      if (rdata[s] !== 32'h0 || rvalid[s] !== 1'b0 || irq[s] !== 1'b0 || wreq[s] !== 1'b0)
        $display("FAIL reset_outputs[%0d]: got rdata=%h rv=%b irq=%b wr=%b, want 0", s,
                 rdata[s], rvalid[s], irq[s], wreq[s]);
      else n_pass++;
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      logic [31:0] a;
      a = (k < 3) ? 32'(32'h1000 + 4 * k) : 32'(32'h1040 + 4 * (k - 3));
      step(3'b000, a, 1'b1, 1'b0, 32'h0);
      for (int s = 0; s < 2; s++) begin
        n_total++;
        if (rvalid[s] !== 1'b1 || rdata[s] !== 32'h0)
          $display("FAIL reset_regs[%0d] @%h: got rv=%b data=%h, want rv=1 data=0", s, a,
                   rvalid[s], rdata[s]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_count();
    repeat (5) step(3'b010, 32'h0, 1'b0, 1'b0, 32'h0);
    step(3'b000, 32'h1004, 1'b1, 1'b0, 32'h0);
    for (int s = 0; s < 2; s++) begin
      n_total++;
      if (rvalid[s] !== 1'b1 || rdata[s] !== 32'd5)
        $display("FAIL count_ch1[%0d]: got rv=%b data=%h, want rv=1 data=5", s, rvalid[s],
                 rdata[s]);
      else n_pass++;
    end
    step(3'b000, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int s = 0; s < 2; s++) begin
      n_total++;
      if (rvalid[s] !== 1'b0 || rdata[s] !== 32'h0)
        $display("FAIL idle_rdata[%0d]: got rv=%b data=%h, want 0/0", s, rvalid[s], rdata[s]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap_irq();
    step(3'b000, 32'h1000, 1'b0, 1'b1, 32'hFF);
    step(3'b001, 32'h0, 1'b0, 1'b0, 32'h0);
    step(3'b000, 32'h1000, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (rdata[0] !== 32'h0 || rdata[1] !== 32'hFF)
      $display("FAIL wrap_cnt0: got wrap=%h sat=%h, want wrap=0 sat=ff", rdata[0], rdata[1]);
    else n_pass++;
    step(3'b000, 32'h1044, 1'b1, 1'b0, 32'h0);
    for (int s = 0; s < 2; s++) begin
      n_total++;
      if (rdata[s] !== 32'h1)
        $display("FAIL wrap_status[%0d]: got %h, want 1", s, rdata[s]);
      else n_pass++;
    end
    step(3'b000, 32'h1048, 1'b0, 1'b1, 32'h1);
    n_total++;
    if (irq !== 2'b00) $display("FAIL irq_latency: got %b, want 00", irq);
    else n_pass++;
    step(3'b000, 32'h0, 1'b0, 1'b0, 32'h0);
    n_total++;
    if (irq !== 2'b11) $display("FAIL irq_set: got %b, want 11", irq);
    else n_pass++;
    step(3'b000, 32'h1044, 1'b0, 1'b1, 32'h1);
    n_total++;
    if (irq !== 2'b11) $display("FAIL irq_hold_after_w1c: got %b, want 11", irq);
    else n_pass++;
    step(3'b000, 32'h0, 1'b0, 1'b0, 32'h0);
    n_total++;
    if (irq !== 2'b00) $display("FAIL irq_clear: got %b, want 00", irq);
    else n_pass++;
  endtask

  task automatic test_saturate();
    step(3'b000, 32'h1008, 1'b0, 1'b1, 32'hFF);
    repeat (3) step(3'b100, 32'h0, 1'b0, 1'b0, 32'h0);
    step(3'b000, 32'h1008, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (rdata[1] !== 32'hFF || rdata[0] !== 32'h2)
      $display("FAIL sat_cnt2: got sat=%h wrap=%h, want sat=ff wrap=2", rdata[1], rdata[0]);
    else n_pass++;
    step(3'b000, 32'h1044, 1'b1, 1'b0, 32'h0);
    for (int s = 0; s < 2; s++) begin
      n_total++;
      if (rdata[s] !== 32'h4) $display("FAIL sat_status[%0d]: got %h, want 4", s, rdata[s]);
      else n_pass++;
    end
    step(3'b000, 32'h1044, 1'b0, 1'b1, 32'h7);
  endtask

  task automatic test_write_priority();
    step(3'b010, 32'h1004, 1'b0, 1'b1, 32'h10);
    step(3'b000, 32'h1004, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (rdata !== '{32'h10, 32'h10})
      $display("FAIL write_over_inc: got %h/%h, want 10", rdata[0], rdata[1]);
    else n_pass++;
    step(3'b000, 32'h1040, 1'b0, 1'b1, 32'h2);
    repeat (4) step(3'b111, 32'h0, 1'b0, 1'b0, 32'h0);
    step(3'b000, 32'h1004, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (rdata !== '{32'h10, 32'h10})
      $display("FAIL freeze_cnt1: got %h/%h, want 10", rdata[0], rdata[1]);
    else n_pass++;
    step(3'b000, 32'h1040, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (rdata !== '{32'h2, 32'h2})
      $display("FAIL ctrl_freeze_rd: got %h/%h, want 2", rdata[0], rdata[1]);
    else n_pass++;
    step(3'b000, 32'h1040, 1'b0, 1'b1, 32'h0);
    step(3'b010, 32'h0, 1'b0, 1'b0, 32'h0);
    step(3'b000, 32'h1004, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (rdata !== '{32'h11, 32'h11})
      $display("FAIL unfreeze_cnt1: got %h/%h, want 11", rdata[0], rdata[1]);
    else n_pass++;
  endtask

  task automatic test_ovf_priority();
    step(3'b000, 32'h1000, 1'b0, 1'b1, 32'hFF);
    step(3'b001, 32'h1044, 1'b0, 1'b1, 32'h1);
    step(3'b000, 32'h1044, 1'b1, 1'b0, 32'h0);
    for (int s = 0; s < 2; s++) begin
      n_total++;
      if (rdata[s] !== 32'h1)
        $display("FAIL ovf_over_w1c[%0d]: got %h, want 1", s, rdata[s]);
      else n_pass++;
    end
  endtask

  task automatic test_clear();
    step(3'b000, 32'h1000, 1'b0, 1'b1, 32'h3);
    step(3'b000, 32'h1004, 1'b0, 1'b1, 32'h4);
    step(3'b000, 32'h1008, 1'b0, 1'b1, 32'hFF);
    step(3'b111, 32'h1040, 1'b0, 1'b1, 32'h1);
    for (int k = 0; k < 5; k++) begin
      logic [31:0] a;
      a = (k < 3) ? 32'(32'h1000 + 4 * k) : ((k == 3) ? 32'h1044 : 32'h1040);
      step(3'b000, a, 1'b1, 1'b0, 32'h0);
      for (int s = 0; s < 2; s++) begin
        n_total++;
        if (rvalid[s] !== 1'b1 || rdata[s] !== 32'h0)
          $display("FAIL clear[%0d] @%h: got rv=%b data=%h, want 1/0", s, a, rvalid[s],
                   rdata[s]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_decode();
    step(3'b000, 32'h1000, 1'b0, 1'b1, 32'h21);
    step(3'b000, 32'h1100, 1'b0, 1'b1, 32'h55);
    step(3'b000, 32'h1002, 1'b0, 1'b1, 32'h77);
    step(3'b000, 32'h0FFC, 1'b0, 1'b1, 32'h66);
    for (int k = 0; k < 5; k++) begin
      logic [31:0] a;
      logic [31:0] want;
      case (k)
        0: a = 32'h1000;
        1: a = 32'h1100;
        2: a = 32'h1002;
        3: a = 32'h0FFC;
        default: a = 32'h104C;
      endcase
      want = (k == 0) ? 32'h21 : 32'h0;
      step(3'b000, a, 1'b1, 1'b0, 32'h0);
      for (int s = 0; s < 2; s++) begin
        n_total++;
        if (rvalid[s] !== 1'b1 || rdata[s] !== want)
          $display("FAIL decode[%0d] @%h: got rv=%b data=%h, want 1/%h", s, a, rvalid[s],
                   rdata[s], want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_read_write_both();
    step(3'b000, 32'h1004, 1'b1, 1'b1, 32'h33);
    n_total++;
    if (rvalid !== 2'b00 || rdata[0] !== 32'h0 || rdata[1] !== 32'h0)
      $display("FAIL rw_both_novalid: got rv=%b data=%h/%h, want 00 and 0", rvalid, rdata[0],
               rdata[1]);
    else n_pass++;
    step(3'b000, 32'h1004, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (rdata[0] !== 32'h33 || rdata[1] !== 32'h33)
      $display("FAIL rw_both_write: got %h/%h, want 33", rdata[0], rdata[1]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 12; k++) begin
      logic [31:0] a;
      a = (k % 4 == 3) ? 32'h1044 : 32'(32'h1000 + 4 * (k % 4));
      step(3'($urandom_range(7)), a, 1'b1, 1'b0, 32'h0);
      for (int s = 0; s < 2; s++) begin
        n_total++;
        if (rvalid[s] !== 1'b1 || rdata[s] !== exp_rd[s])
          $display("FAIL b2b[%0d] @%h: got rv=%b data=%h, want 1/%h", s, a, rvalid[s],
                   rdata[s], exp_rd[s]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] addrs [12];
    addrs = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1040, 32'h1044, 32'h1048,
              32'h104C, 32'h10FC, 32'h1100, 32'h1002, 32'h0FFC};
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      logic [31:0] wd;
      int op;
      a = addrs[$urandom_range(11)];
      op = int'($urandom_range(3));
      wd = $urandom;
      if (a == 32'h1040 && $urandom_range(7) != 0) wd[0] = 1'b0;
      if (a < 32'h100C && $urandom_range(1) == 0) wd[7:0] = 8'hFD + 8'($urandom_range(2));
      step(3'($urandom_range(7)), a, op == 1 || op == 3, op >= 2, wd);
      for (int s = 0; s < 2; s++) begin
        n_total++;
        if (rvalid[s] !== exp_v || rdata[s] !== exp_rd[s] || irq[s] !== m_irq[s])
          $display("FAIL random[%0d] cyc %0d @%h: got rv=%b data=%h irq=%b, want %b/%h/%b",
                   s, k, a, rvalid[s], rdata[s], irq[s], exp_v, exp_rd[s], m_irq[s]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midread();
    // Reset arriving after the read was captured must kill the pending valid at once.
    avs_address = 32'h1004; avs_read = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_total++;
    if (rvalid !== 2'b00 || rdata[0] !== 32'h0 || rdata[1] !== 32'h0)
      $display("FAIL rst_after_capture: got rv=%b data=%h/%h, want 0", rvalid, rdata[0],
               rdata[1]);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0; avs_read = 1'b0; avs_address = 32'h0;
    model_reset();
    // Reset arriving before the capturing edge must drop the read entirely.
    avs_address = 32'h1004; avs_read = 1'b1;
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if (rvalid !== 2'b00 || rdata[0] !== 32'h0 || rdata[1] !== 32'h0 || irq !== 2'b00)
      $display("FAIL rst_during_read: got rv=%b data=%h/%h irq=%b, want 0", rvalid, rdata[0],
               rdata[1], irq);
    else n_pass++;
    avs_read = 1'b0; avs_address = 32'h0;
    rst = 1'b0;
    step(3'b000, 32'h0, 1'b0, 1'b0, 32'h0);
    n_total++;
    if (rvalid !== 2'b00) $display("FAIL no_valid_after_rst: got %b, want 00", rvalid);
    else n_pass++;
    step(3'b000, 32'h1004, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (rdata[0] !== 32'h0 || rdata[1] !== 32'h0 || rvalid !== 2'b11)
      $display("FAIL cnt_after_rst: got rv=%b data=%h/%h, want 11 and 0", rvalid, rdata[0],
               rdata[1]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap_irq();
    test_saturate();
    test_write_priority();
    test_ovf_priority();
    test_clear();
    test_decode();
    test_read_write_both();
    test_back_to_back();
    test_random();
    test_reset_midread();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
